light_conflict_monitor: RTL and testbench
=========================================

Name: light_conflict_monitor

Overview:
Independent safety checker on the 7-bit lamp bus driven by the controller FSM. It reads the lamp bus every clock and checks lamp encoding, cross-direction conflicts, walk legality, phase ordering and minimum yellow dwell. On any violation it latches a fault code. It then overrides the lamp output with an all-red flashing pattern until software clears the fault. It sits between the FSM lamp output and the board LED pins, and uses the clock divider's 1 Hz enable.

Parameters:
YEL_MIN_S, 2, minimum yellow dwell in divider ticks (seconds), range 1..15
CNT_W, 4, width of the yellow dwell counters; saturate at 2^CNT_W-1

Ports:
clk  input  1  system clock
globalReset  input  1  asynchronous, active-low reset
tick  input  1  one-cycle 1 Hz enable pulse from the clock divider
ledIn  input  7  lamp bus from FSM: [6]mainG [5]mainY [4]mainR [3]sideG [2]sideY [1]sideR [0]walk
faultClear  input  1  synchronous, level-sampled request to leave FAULT
safeLED  output  7  registered lamp bus to pins, same bit map as ledIn
fault  output  1  high while in FAULT
faultCode  output  3  code of the first latched violation; 0 when no fault

Behaviour:
- Reset (globalReset=0, async):
  - State is MONITOR.
  - safeLED=7'b0010010 (both reds), fault=0, faultCode=0.
  - prevValid=0; both dwell counters 0; flash=1.
- ledQ is a 1-cycle registered copy of ledIn. prevValid is set at the first clock edge after reset release.
- Checks, evaluated on ledIn (and ledQ for checks 4/5) at each edge while in MONITOR:
  - 1 lamp encoding: main or side triple is not one-hot.
  - 2 conflict: mainR=0 and sideR=0.
  - 3 walk: walk=1 while either red is 0.
  - 4 illegal transition, per direction: only hold, G->Y, Y->R and R->G are legal. Enabled only when prevValid=1.
  - 5 short yellow: a Y->R transition with dwell counter < YEL_MIN_S.
- Priority: when several checks fail in the same cycle, the lowest code is latched.
- Latency: a violation on ledIn at edge k gives fault=1 and faultCode valid after edge k.
- Dwell counters, one per direction:
  - Cleared to 0 on the edge where the direction enters Y.
  - Incremented on tick while the direction is in Y; saturates at 15.
  - A tick coincident with the Y->R edge is not counted before the compare.
- States:
  - MONITOR:
    - safeLED <= ledIn (1-cycle latency).
    - On any violation: go to FAULT, set flash<=1, latch the code.
  - FAULT:
    - safeLED <= {2'b00, flash, 2'b00, flash, 1'b0}.
    - flash toggles on each tick.
    - Further violations are ignored; faultCode holds the first one.
  - FAULT -> MONITOR:
    - Taken on an edge with faultClear=1 and ledIn passing checks 1-3.
    - That edge also clears faultCode, sets prevValid=0 (transition history discarded) and clears both counters.
    - safeLED resumes following ledIn from the next edge.
    - If faultClear=1 but ledIn still violates checks 1-3, stay in FAULT and keep the original code.
- faultClear while in MONITOR is ignored.
- Reset in FAULT returns everything to reset values immediately.
- ledIn changing in the same cycle as tick: the transition check uses the new value, and the tick is credited per the dwell-counter rule above.

Decomposition:
- Shared package:
  - Lamp bit index constants (MAIN_G..WALK).
  - Fault code constants FLT_NONE=0, FLT_ONEHOT=1, FLT_CONFLICT=2, FLT_WALK=3, FLT_SEQ=4, FLT_SHORT_Y=5.
  - SAFE_ALL_RED pattern.
  - State encoding MONITOR/FAULT.
- One sub-module: yellow_dwell_counter (inputs clk, globalReset, enterY, inY, tick; output count). Instantiated twice, for main and side.

Test Plan:
- Legal cycle: main G->Y->R with side R throughout, 3 ticks in Y, YEL_MIN_S=2 -> fault stays 0 and safeLED equals ledIn delayed 1 cycle.
- Conflict: ledIn=7'b1001000 (mainG+sideG) -> after 1 edge fault=1, faultCode=2; safeLED=7'b0010010 then 7'b0000000 after the next tick, alternating per tick.
- Simultaneous: ledIn=7'b1101001 (mainG+mainY, side G, walk) -> faultCode=1, not 2 or 3.
- Short yellow: main Y for 1 tick then R, YEL_MIN_S=2 -> faultCode=5. Repeat with a tick on the exit edge after 1 counted tick -> still 5.
- Illegal sequence: main R->Y directly (prevValid=1) -> faultCode=4. The same pattern on the first edge after reset -> no code-4 fault.
- Clear handling:
  - faultClear=1 while ledIn=7'b0010010 -> fault=0 next edge and safeLED follows ledIn one edge later.
  - faultClear=1 while ledIn=7'b1001000 -> fault stays 1, faultCode unchanged.
  - Async reset asserted mid-FAULT -> outputs at reset values immediately.

Source files
------------

// File: rtl/light_conflict_monitor_pkg.sv
// Shared definitions for the lamp-bus safety monitor: lamp bit map, fault codes,
// the safe all-red pattern, the monitor state type and lamp-triple helpers.
package light_conflict_monitor_pkg;

    localparam int unsigned MAIN_G = 6;
    localparam int unsigned MAIN_Y = 5;
    localparam int unsigned MAIN_R = 4;
    localparam int unsigned SIDE_G = 3;
    localparam int unsigned SIDE_Y = 2;
    localparam int unsigned SIDE_R = 1;
    localparam int unsigned WALK   = 0;

    localparam logic [2:0] FLT_NONE     = 3'd0;
    localparam logic [2:0] FLT_ONEHOT   = 3'd1;
    localparam logic [2:0] FLT_CONFLICT = 3'd2;
    localparam logic [2:0] FLT_WALK     = 3'd3;
    localparam logic [2:0] FLT_SEQ      = 3'd4;
    localparam logic [2:0] FLT_SHORT_Y  = 3'd5;

    localparam logic [6:0] SAFE_ALL_RED = 7'b0010010;

    // Lamp triple ordering is {G, Y, R}
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    typedef enum logic {
        MONITOR = 1'b0,
        FAULT   = 1'b1
    } mon_state_t;

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == LAMP_G) || (v == LAMP_Y) || (v == LAMP_R);
    endfunction

    function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
        return (prev == cur) ||
               ((prev == LAMP_G) && (cur == LAMP_Y)) ||
               ((prev == LAMP_Y) && (cur == LAMP_R)) ||
               ((prev == LAMP_R) && (cur == LAMP_G));
    endfunction

endpackage

// File: rtl/light_conflict_monitor_dwell.sv
// Per-direction yellow dwell counter: counts divider ticks spent in yellow,
// cleared on entry to yellow, saturating at all-ones.
module yellow_dwell_counter
    import light_conflict_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             enterY,
    input  logic             inY,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            count <= '0;
        end else if (enterY) begin
            count <= '0;
        end else if (inY && tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between the controller lamp bus and the LED pins: latches the
// first rule violation and forces a flashing all-red pattern until cleared.
module light_conflict_monitor
    import light_conflict_monitor_pkg::*;
#(
    parameter int unsigned YEL_MIN_S = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       globalReset,
    input  logic       tick,
    input  logic [6:0] ledIn,
    input  logic       faultClear,
    output logic [6:0] safeLED,
    output logic       fault,
    output logic [2:0] faultCode
);

    localparam logic [CNT_W-1:0] YEL_MIN = CNT_W'(YEL_MIN_S);

    mon_state_t       r_state;
    logic [5:0]       r_lampQ;
    logic             r_prevValid;
    logic             r_flash;

    logic [2:0]       w_curM, w_curS, w_prevM, w_prevS;
    logic [CNT_W-1:0] w_cntM, w_cntS;
    logic             w_chkOneHot, w_chkConflict, w_chkWalk, w_chkSeq, w_chkShortY;
    logic             w_basicOk, w_recover, w_flashNext;
    logic [2:0]       w_code;
    logic [6:0]       w_faultLed;

    assign w_curM  = ledIn[MAIN_G:MAIN_R];
    assign w_curS  = ledIn[SIDE_G:SIDE_R];
    assign w_prevM = r_lampQ[5:3];
    assign w_prevS = r_lampQ[2:0];

    assign w_chkOneHot   = !one_hot3(w_curM) || !one_hot3(w_curS);
    assign w_chkConflict = !ledIn[MAIN_R] && !ledIn[SIDE_R];
    assign w_chkWalk     = ledIn[WALK] && (!ledIn[MAIN_R] || !ledIn[SIDE_R]);
    assign w_chkSeq      = r_prevValid &&
                           (!legal_step(w_prevM, w_curM) || !legal_step(w_prevS, w_curS));
    // Registered count excludes any tick on the exit edge itself
    assign w_chkShortY   = r_prevValid &&
                           (((w_prevM == LAMP_Y) && (w_curM == LAMP_R) && (w_cntM < YEL_MIN)) ||
                            ((w_prevS == LAMP_Y) && (w_curS == LAMP_R) && (w_cntS < YEL_MIN)));

    always_comb begin
        w_code = FLT_NONE;
        if (w_chkOneHot)        w_code = FLT_ONEHOT;
        else if (w_chkConflict) w_code = FLT_CONFLICT;
        else if (w_chkWalk)     w_code = FLT_WALK;
        else if (w_chkSeq)      w_code = FLT_SEQ;
        else if (w_chkShortY)   w_code = FLT_SHORT_Y;
    end

    assign w_basicOk   = !(w_chkOneHot || w_chkConflict || w_chkWalk);
    assign w_recover   = (r_state == FAULT) && faultClear && w_basicOk;
    assign w_flashNext = r_flash ^ tick;
    assign w_faultLed  = {2'b00, w_flashNext, 2'b00, w_flashNext, 1'b0};

    yellow_dwell_counter #(.CNT_W(CNT_W)) u_dwell_main (
        .clk         (clk),
        .globalReset (globalReset),
        .enterY      (((w_curM == LAMP_Y) && (w_prevM != LAMP_Y)) || w_recover),
        .inY         (w_curM == LAMP_Y),
        .tick        (tick),
        .count       (w_cntM)
    );

    yellow_dwell_counter #(.CNT_W(CNT_W)) u_dwell_side (
        .clk         (clk),
        .globalReset (globalReset),
        .enterY      (((w_curS == LAMP_Y) && (w_prevS != LAMP_Y)) || w_recover),
        .inY         (w_curS == LAMP_Y),
        .tick        (tick),
        .count       (w_cntS)
    );

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_state     <= MONITOR;
            r_lampQ     <= SAFE_ALL_RED[6:1];
            r_prevValid <= 1'b0;
            r_flash     <= 1'b1;
            safeLED     <= SAFE_ALL_RED;
            fault       <= 1'b0;
            faultCode   <= FLT_NONE;
        end else begin
            r_lampQ     <= ledIn[6:1];
            r_prevValid <= 1'b1;
            case (r_state)
                MONITOR: begin
                    if (w_code != FLT_NONE) begin
                        r_state   <= FAULT;
                        r_flash   <= 1'b1;
                        fault     <= 1'b1;
                        faultCode <= w_code;
                        safeLED   <= SAFE_ALL_RED;
                    end else begin
                        safeLED   <= ledIn;
                    end
                end
                FAULT: begin
                    r_flash <= w_flashNext;
                    safeLED <= w_faultLed;
                    if (w_recover) begin
                        r_state     <= MONITOR;
                        fault       <= 1'b0;
                        faultCode   <= FLT_NONE;
                        r_prevValid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Randomized and directed bench for light_conflict_monitor, checked against a
// colour-level reference model of the lamp-safety rules.
module tb_light_conflict_monitor;

    localparam int unsigned YEL = 2;
    localparam logic [6:0] ALLRED = 7'b0010010;

    logic       clk = 1'b0;
    logic       globalReset = 1'b1;
    logic       tick = 1'b0;
    logic       faultClear = 1'b0;
    logic [6:0] ledIn = 7'b0010010;
    logic [6:0] safeLED;
    logic       fault;
    logic [2:0] faultCode;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit         m_fault;
    logic [2:0] m_code;
    bit         m_flash;
    logic [6:0] m_safe;
    bit         m_pv;
    logic [6:0] m_prev;
    int         m_dwell [2];

    always #5 clk = ~clk;

    light_conflict_monitor #(.YEL_MIN_S(YEL), .CNT_W(4)) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .tick        (tick),
        .ledIn       (ledIn),
        .faultClear  (faultClear),
        .safeLED     (safeLED),
        .fault       (fault),
        .faultCode   (faultCode)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // colour index: 0 green, 1 yellow, 2 red, -1 not a single lamp
    function automatic int colour(input logic [2:0] t);
        case (t)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] lamp(input int c);
        return (c == 0) ? 3'b100 : (c == 1) ? 3'b010 : 3'b001;
    endfunction

    task automatic model_reset();
        m_fault = 0; m_code = 3'd0; m_flash = 1; m_safe = ALLRED;
        m_pv = 0; m_prev = ALLRED; m_dwell[0] = 0; m_dwell[1] = 0;
    endtask

    task automatic model_edge(input logic [6:0] led, input bit tk, input bit clr);
        int cur [2];
        int prv [2];
        bit bad1, bad2, bad3, bad4, bad5, pv_next;
        logic [2:0] code;
        cur[0] = colour(led[6:4]);    cur[1] = colour(led[3:1]);
        prv[0] = colour(m_prev[6:4]); prv[1] = colour(m_prev[3:1]);
        bad1 = (cur[0] < 0) || (cur[1] < 0);
        bad2 = !led[4] && !led[1];
        bad3 = led[0] && !(led[4] && led[1]);
        bad4 = 0; bad5 = 0;
        for (int unsigned d = 0; d < 2; d++) begin
            if (m_pv && !((cur[d] == prv[d]) || (prv[d] >= 0 && cur[d] == (prv[d] + 1) % 3)))
                bad4 = 1;
            if (m_pv && prv[d] == 1 && cur[d] == 2 && m_dwell[d] < int'(YEL))
                bad5 = 1;
        end
        code = bad1 ? 3'd1 : bad2 ? 3'd2 : bad3 ? 3'd3 : bad4 ? 3'd4 : bad5 ? 3'd5 : 3'd0;
        for (int unsigned d = 0; d < 2; d++) begin
            if (cur[d] == 1 && prv[d] != 1)      m_dwell[d] = 0;
            else if (cur[d] == 1 && tk)          m_dwell[d] = (m_dwell[d] >= 15) ? 15 : m_dwell[d] + 1;
        end
        m_prev = led;
        pv_next = 1;
        if (!m_fault) begin
            if (code != 3'd0) begin
                m_fault = 1; m_code = code; m_flash = 1; m_safe = ALLRED;
            end else begin
                m_safe = led;
            end
        end else begin
            m_flash = m_flash ^ tk;
            m_safe = m_flash ? ALLRED : 7'b0000000;
            if (clr && !(bad1 || bad2 || bad3)) begin
                m_fault = 0; m_code = 3'd0; pv_next = 0;
                m_dwell[0] = 0; m_dwell[1] = 0;
            end
        end
        m_pv = pv_next;
    endtask

    task automatic apply(input logic [6:0] led, input bit tk, input bit clr, input string tag);
        ledIn = led; tick = tk; faultClear = clr;
        @(posedge clk);
        model_edge(led, tk, clr);
        #1;
        chk({tag, ".safeLED"}, {1'b0, safeLED}, {1'b0, m_safe});
        chk({tag, ".fault"}, {7'b0, fault}, {7'b0, m_fault});
        chk({tag, ".faultCode"}, {5'b0, faultCode}, {5'b0, m_code});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".safeLED"}, {1'b0, safeLED}, {1'b0, ALLRED});
        chk({tag, ".fault"}, {7'b0, fault}, 8'd0);
        chk({tag, ".faultCode"}, {5'b0, faultCode}, 8'd0);
    endtask

    task automatic do_reset();
        ledIn = ALLRED; tick = 0; faultClear = 0;
        globalReset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        globalReset = 1'b1;
    endtask

    initial begin
        int gm, gs;
        bit walk, tk, clr;
        logic [6:0] led;

        #1;
        do_reset();

        // legal main cycle G -> Y (3 ticks) -> R with side red
        apply(ALLRED, 0, 0, "legal");
        apply(7'b1000010, 0, 0, "legal");
        apply(7'b1000010, 1, 0, "legal");
        apply(7'b0100010, 0, 0, "legal");
        apply(7'b0100010, 1, 0, "legal");
        apply(7'b0100010, 0, 0, "legal");
        apply(7'b0100010, 1, 0, "legal");
        apply(7'b0100010, 1, 0, "legal");
        apply(ALLRED, 0, 0, "legal");
        chk("legal_nofault", {7'b0, fault}, 8'd0);

        // both greens, then flashing, failed and successful clear
        apply(7'b1001000, 0, 0, "conflict");
        chk("conflict_code", {5'b0, faultCode}, 8'd2);
        chk("conflict_red", {1'b0, safeLED}, {1'b0, ALLRED});
        apply(7'b1001000, 1, 0, "flash");
        chk("flash_dark", {1'b0, safeLED}, 8'd0);
        apply(7'b1001000, 1, 0, "flash");
        apply(7'b1001000, 0, 1, "clr_bad");
        chk("clr_bad_code", {5'b0, faultCode}, 8'd2);
        apply(ALLRED, 0, 1, "clr_ok");
        chk("clr_ok_fault", {7'b0, fault}, 8'd0);
        apply(7'b1000010, 0, 0, "resume");
        chk("resume_follow", {1'b0, safeLED}, 8'h42);

        // several simultaneous violations
        apply(7'b1101001, 0, 0, "simul");
        chk("simul_code", {5'b0, faultCode}, 8'd1);
        apply(ALLRED, 0, 1, "clr");

        // short yellow: one counted tick
        apply(ALLRED, 0, 0, "shorty");
        apply(7'b1000010, 0, 0, "shorty");
        apply(7'b0100010, 0, 0, "shorty");
        apply(7'b0100010, 1, 0, "shorty");
        apply(7'b0100010, 0, 0, "shorty");
        apply(ALLRED, 0, 0, "shorty");
        chk("shorty_code", {5'b0, faultCode}, 8'd5);
        apply(ALLRED, 0, 1, "clr");

        // short yellow with a tick on the exit edge
        apply(ALLRED, 0, 0, "shorty2");
        apply(7'b1000010, 0, 0, "shorty2");
        apply(7'b0100010, 0, 0, "shorty2");
        apply(7'b0100010, 1, 0, "shorty2");
        apply(ALLRED, 1, 0, "shorty2");
        chk("shorty2_code", {5'b0, faultCode}, 8'd5);
        apply(ALLRED, 0, 1, "clr");

        // red straight to yellow
        apply(ALLRED, 0, 0, "seq");
        apply(7'b0100010, 0, 0, "seq");
        chk("seq_code", {5'b0, faultCode}, 8'd4);

        // async reset in the middle of FAULT
        #2;
        globalReset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        globalReset = 1'b1;

        // same pattern on first edge after reset is not a sequence fault
        apply(7'b0100010, 0, 0, "seq_first");
        chk("seq_first_nofault", {7'b0, fault}, 8'd0);

        // randomized traffic with occasional corruption, ticks and clears
        do_reset();
        gm = 2; gs = 2;
        for (int unsigned i = 0; i < 600; i++) begin
            tk  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 4) == 0);
            if (gm != 2) begin
                if ($urandom_range(0, 3) == 0) gm = gm + 1;
            end else if (gs != 2) begin
                if ($urandom_range(0, 3) == 0) gs = gs + 1;
            end else begin
                case ($urandom_range(0, 3))
                    0:       gm = 0;
                    1:       gs = 0;
                    default: ;
                endcase
            end
            walk = (gm == 2) && (gs == 2) && ($urandom_range(0, 1) == 1);
            led = {lamp(gm), lamp(gs), walk};
            if ($urandom_range(0, 24) == 0) led = 7'($urandom);
            apply(led, tk, clr, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
